// File: rtl/display_mux_scheduler.sv
// display_mux_scheduler
//   Time-multiplexes NDIG BCD digits onto one shared 7-segment decoder and a
//   common-anode display. Each digit slot is TICK_DIV cycles: BLANK_CYC cycles
//   with every anode off (anti-ghosting), then the digit is lit. The BCD word,
//   decimal points and the leading-zero flag are snapshotted once per frame,
//   at entry to the digit-0 slot, so a frame never mixes old and new data.
//
// Ports
//   clk         system clock
//   reset       asynchronous active-low reset
//   en          1 = scan, 0 = all digits off and scheduler idle
//   lz_blank    1 = suppress leading zeros
//   bcd_in      digit i at [4i+3:4i], digit 0 least significant
//   dp_in       decimal point per digit, active-high
//   bcd_out     BCD of the current digit, to the decoder
//   dp_out      decimal point of the current digit, active-high
//   an          anodes, active-low, at most one bit low
//   digit_idx   index of the current slot
//   frame_start one-cycle pulse on the first cycle of the digit-0 slot
module display_mux_scheduler #(
    parameter int NDIG      = 4,
    parameter int TICK_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    localparam int IW = $clog2(NDIG),
    localparam int CW = $clog2(TICK_DIV)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              lz_blank,
    input  logic [4*NDIG-1:0] bcd_in,
    input  logic [NDIG-1:0]   dp_in,
    output logic [3:0]        bcd_out,
    output logic              dp_out,
    output logic [NDIG-1:0]   an,
    output logic [IW-1:0]     digit_idx,
    output logic              frame_start
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_SHOW  = 2'd2;

    localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] snap_bcd_q, snap_bcd_d;
    logic [NDIG-1:0]   snap_dp_q, snap_dp_d;
    logic              snap_lz_q, snap_lz_d;
    logic              take;

    logic [3:0]        bcd_out_q, bcd_out_d;
    logic              dp_out_q, dp_out_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic              fs_q;

    logic [NDIG-1:0]   supp;
    logic              zero_above;
    logic              active, lit;

    // Slot sequencing; the counter spans BLANK+SHOW of one slot.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        take    = 1'b0;
        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    take    = 1'b1;
                end
                S_BLANK: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == BLANK_END) state_d = S_SHOW;
                end
                S_SHOW: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_BLANK;
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                        take    = (idx_q == IDX_LAST);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    assign snap_bcd_d = take ? bcd_in   : snap_bcd_q;
    assign snap_dp_d  = take ? dp_in    : snap_dp_q;
    assign snap_lz_d  = take ? lz_blank : snap_lz_q;

    // Digit k is suppressed when it and all higher digits are zero; digit 0
    // always shows. Codes 10..15 count as nonzero.
    always_comb begin
        supp       = '0;
        zero_above = 1'b1;
        for (int k = NDIG - 1; k >= 1; k--) begin
            zero_above = zero_above & (snap_bcd_d[4*k +: 4] == 4'd0);
            supp[k]    = snap_lz_d & zero_above;
        end
    end

    // Outputs are computed from next state so the registered values line up
    // with the slot they belong to; bcd/dp change at BLANK entry, ahead of the
    // anode going low.
    always_comb begin
        active    = (state_d != S_IDLE);
        lit       = (state_d == S_SHOW) && !supp[idx_d];
        bcd_out_d = active ? snap_bcd_d[4*idx_d +: 4] : 4'd0;
        dp_out_d  = active & snap_dp_d[idx_d] & ~supp[idx_d];
        an_d      = lit ? ~(NDIG'(1) << idx_d) : '1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            snap_bcd_q <= '0;
            snap_dp_q  <= '0;
            snap_lz_q  <= 1'b0;
            bcd_out_q  <= 4'd0;
            dp_out_q   <= 1'b0;
            an_q       <= '1;
            fs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            snap_bcd_q <= snap_bcd_d;
            snap_dp_q  <= snap_dp_d;
            snap_lz_q  <= snap_lz_d;
            bcd_out_q  <= bcd_out_d;
            dp_out_q   <= dp_out_d;
            an_q       <= an_d;
            fs_q       <= take;
        end
    end

    assign bcd_out     = bcd_out_q;
    assign dp_out      = dp_out_q;
    assign an          = an_q;
    assign digit_idx   = idx_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_display_mux_scheduler.sv
module tb_display_mux_scheduler;

    localparam int NDIG = 4;
    localparam int TDIV = 8;
    localparam int BLK  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        lz_blank = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  bcd_out;
    logic        dp_out;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    display_mux_scheduler #(.NDIG(NDIG), .TICK_DIV(TDIV), .BLANK_CYC(BLK)) dut (
        .clk(clk), .reset(reset), .en(en), .lz_blank(lz_blank),
        .bcd_in(bcd_in), .dp_in(dp_in), .bcd_out(bcd_out), .dp_out(dp_out),
        .an(an), .digit_idx(digit_idx), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]      bcd;
        logic [3:0]       dp;
        logic             lz;
        logic [3:0][3:0]  e_an;   // anodes during SHOW, indexed by digit
        logic [3:0]       e_dp;   // dp_out while digit is in SHOW
    } vec_t;

    vec_t tab[6];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle k counted from the edge that left IDLE.
    task automatic chk_cyc(input int k, input logic [3:0] e_an_show,
                           input logic [3:0] e_bcd, input logic e_dp);
        int c, d;
        c = k % TDIV;
        d = (k / TDIV) % NDIG;
        chk("digit_idx", digit_idx, d);
        chk("an", an, (c < BLK) ? 4'hF : e_an_show);
        chk("bcd_out", bcd_out, e_bcd);
        chk("frame_start", frame_start, (k % (NDIG*TDIV)) == 0);
        if (c >= BLK) chk("dp_out", dp_out, e_dp);
    endtask

    task automatic restart(input logic [15:0] b, input logic [3:0] p, input logic z);
        en = 1'b0;
        tick();
        bcd_in = b; dp_in = p; lz_blank = z;
        en = 1'b1;
    endtask

    initial begin
        logic [15:0] snap;
        logic [15:0] s_bcd, c_bcd;
        logic [3:0]  s_dp, c_dp, sup, e_an;
        logic        s_lz, c_lz, za, lit;
        int d, c;

        tab[0] = '{16'h1234, 4'b0000, 1'b0, '{4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'b0000};
        tab[1] = '{16'h0040, 4'b0000, 1'b1, '{4'b1111, 4'b1111, 4'b1101, 4'b1110}, 4'b0000};
        tab[2] = '{16'h0000, 4'b1111, 1'b1, '{4'b1111, 4'b1111, 4'b1111, 4'b1110}, 4'b0001};
        tab[3] = '{16'h0A00, 4'b1010, 1'b1, '{4'b1111, 4'b1011, 4'b1101, 4'b1110}, 4'b0010};
        tab[4] = '{16'h0000, 4'b0101, 1'b0, '{4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'b0101};
        tab[5] = '{16'h9000, 4'b1000, 1'b1, '{4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'b1000};

        // Reset state
        tick(); tick();
        chk("rst_an", an, 4'hF);
        chk("rst_bcd", bcd_out, 0);
        chk("rst_dp", dp_out, 0);
        chk("rst_idx", digit_idx, 0);
        chk("rst_fs", frame_start, 0);
        @(negedge clk);
        reset = 1'b1;

        // Table: one frame plus the next frame_start per vector
        for (int v = 0; v < 6; v++) begin
            restart(tab[v].bcd, tab[v].dp, tab[v].lz);
            for (int k = 0; k <= NDIG*TDIV; k++) begin
                tick();
                d = (k / TDIV) % NDIG;
                chk_cyc(k, tab[v].e_an[d], tab[v].bcd[4*d +: 4], tab[v].e_dp[d]);
            end
        end

        // Mid-frame input change is ignored until the next frame
        restart(16'h1234, 4'b0000, 1'b0);
        for (int k = 0; k < 2*NDIG*TDIV; k++) begin
            tick();
            d = (k / TDIV) % NDIG;
            snap = (k < NDIG*TDIV) ? 16'h1234 : 16'h5678;
            chk_cyc(k, ~(4'b0001 << d), snap[4*d +: 4], 1'b0);
            if (k == 12) bcd_in = 16'h5678;
        end

        // en dropped during digit-2 SHOW, re-raised 5 cycles later
        restart(16'h1234, 4'b0000, 1'b0);
        for (int k = 0; k <= 20; k++) begin
            tick();
            d = (k / TDIV) % NDIG;
            snap = 16'h1234;
            chk_cyc(k, ~(4'b0001 << d), snap[4*d +: 4], 1'b0);
        end
        en = 1'b0;
        tick();
        chk("endrop_an", an, 4'hF);
        chk("endrop_idx", digit_idx, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_an", an, 4'hF);
        end
        en = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            tick();
            d = (k / TDIV) % NDIG;
            snap = 16'h1234;
            chk_cyc(k, ~(4'b0001 << d), snap[4*d +: 4], 1'b0);
        end

        // Async reset mid-SHOW, no clock edge needed
        restart(16'h1234, 4'b0000, 1'b0);
        for (int k = 0; k <= 4; k++) begin
            tick();
            d = (k / TDIV) % NDIG;
            snap = 16'h1234;
            chk_cyc(k, ~(4'b0001 << d), snap[4*d +: 4], 1'b0);
        end
        #2 reset = 1'b0;
        #1;
        chk("arst_an", an, 4'hF);
        chk("arst_bcd", bcd_out, 0);
        chk("arst_idx", digit_idx, 0);
        chk("arst_dp", dp_out, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            tick();
            d = (k / TDIV) % NDIG;
            snap = 16'h1234;
            chk_cyc(k, ~(4'b0001 << d), snap[4*d +: 4], 1'b0);
        end

        // Random 4-frame run with inputs changing every cycle
        c_bcd = 16'h0305; c_dp = 4'b1001; c_lz = 1'b1;
        restart(c_bcd, c_dp, c_lz);
        s_bcd = '0; s_dp = '0; s_lz = 1'b0;
        for (int k = 0; k < 4*NDIG*TDIV; k++) begin
            tick();
            if (k % (NDIG*TDIV) == 0) begin
                s_bcd = c_bcd; s_dp = c_dp; s_lz = c_lz;
            end
            d = (k / TDIV) % NDIG;
            c = k % TDIV;
            sup = '0;
            za = 1'b1;
            for (int j = NDIG - 1; j >= 1; j--) begin
                za = za & (s_bcd[4*j +: 4] == 4'd0);
                sup[j] = s_lz & za;
            end
            lit = (c >= BLK) && !sup[d];
            e_an = lit ? ~(4'b0001 << d) : 4'hF;
            chk("rnd_an", an, e_an);
            chk("rnd_onecold", ($countones(~an) <= 1), 1);
            chk("rnd_bcd", bcd_out, s_bcd[4*d +: 4]);
            if (lit) chk("rnd_dp", dp_out, s_dp[d]);
            for (int j = 0; j < NDIG; j++)
                c_bcd[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            c_dp = 4'($urandom_range(0, 15));
            c_lz = 1'($urandom_range(0, 1));
            bcd_in = c_bcd; dp_in = c_dp; lz_blank = c_lz;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
